// File: rtl/poly_vec_addsub.sv
// rtl/poly_vec_addsub.sv - in-place coefficient-wise modular add/sub over a vector of polynomials in Z_q
// Optional operand range checking is enabled by defining POLY_VEC_RANGE_CHK_EN.
module poly_vec_addsub #(
  parameter int K = 3,
  parameter int N = 256,
  parameter int W = 12,
  parameter int Q = 3329,
  localparam int AW = $clog2(K*N),
  localparam int LW = $clog2(K+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [LW-1:0] len,
  output logic          done,
  output logic          busy,
  output logic          range_err,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_din,
  output logic [W-1:0]  a_dout,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_din,
  output logic [W-1:0]  b_dout
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    op_q, op_d;
  logic [LW-1:0] len_q, len_d;
  logic          done_q, done_d;

  logic [W-1:0]  mem_a [K*N];
  logic [W-1:0]  mem_b [K*N];
  logic [W-1:0]  a_rd_q, b_rd_q;

  logic [LW-1:0] len_c;
  logic [AW-1:0] m_last;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          wr_a_en, wr_b_en;
  logic [AW-1:0] wr_a_addr;
  logic [W-1:0]  wr_a_data;

  logic [W:0]    sum, d_ab, d_ba;
  logic [W-1:0]  res;

  assign len_c  = (32'(len) > K) ? LW'(K) : len;
  assign m_last = AW'(32'(len_q) * N - 1);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign a_dout = a_rd_q;
  assign b_dout = b_rd_q;

  // Modular arithmetic on the operands read out of the RAMs this cycle.
  always_comb begin
    sum  = {1'b0, a_rd_q} + {1'b0, b_rd_q};
    d_ab = {1'b0, a_rd_q} - {1'b0, b_rd_q};
    d_ba = {1'b0, b_rd_q} - {1'b0, a_rd_q};
    res  = '0;
    case (op_q)
      2'b00:   res = (sum >= (W+1)'(Q)) ? W'(sum - (W+1)'(Q)) : sum[W-1:0];
      2'b01:   res = d_ab[W] ? W'(d_ab + (W+1)'(Q)) : d_ab[W-1:0];
      2'b10:   res = d_ba[W] ? W'(d_ba + (W+1)'(Q)) : d_ba[W-1:0];
      default: res = (b_rd_q == '0) ? '0 : W'(Q) - b_rd_q;
    endcase
  end

  // Sweep sequencing and RAM port steering; external access only in idle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    len_d     = len_q;
    done_d    = 1'b0;
    rd_addr_a = a_addr;
    rd_addr_b = b_addr;
    wr_a_en   = 1'b0;
    wr_b_en   = 1'b0;
    wr_a_addr = a_addr;
    wr_a_data = a_din;
    case (state_q)
      S_IDLE: begin
        wr_a_en = a_we;
        wr_b_en = b_we;
        if (start) begin
          op_d  = op;
          len_d = len_c;
          idx_d = '0;
          if (len_c == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        wr_a_en   = 1'b1;
        wr_a_addr = idx_q;
        wr_a_data = res;
        if (idx_q == m_last) begin
          rd_addr_a = idx_q;
          rd_addr_b = idx_q;
          state_d   = S_DONE;
          done_d    = 1'b1;
        end else begin
          rd_addr_a = idx_q + AW'(1);
          rd_addr_b = idx_q + AW'(1);
          idx_d     = idx_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= 2'b00;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  // Operand RAMs with registered read data.
  always_ff @(posedge clk) begin
    if (wr_a_en) mem_a[wr_a_addr] <= wr_a_data;
    if (wr_b_en) mem_b[b_addr] <= b_din;
    a_rd_q <= mem_a[rd_addr_a];
    b_rd_q <= mem_b[rd_addr_b];
  end

`ifdef POLY_VEC_RANGE_CHK_EN
  logic range_q, range_d, oor;

  // Sticky out-of-range flag; negation only looks at b.
  always_comb begin
    oor     = (b_rd_q >= W'(Q)) || ((op_q != 2'b11) && (a_rd_q >= W'(Q)));
    range_d = range_q;
    if ((state_q == S_IDLE) && start) range_d = 1'b0;
    else if ((state_q == S_RUN) && oor) range_d = 1'b1;
  end

  // Range flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) range_q <= 1'b0;
    else        range_q <= range_d;
  end

  assign range_err = range_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
